// File: rtl/math_pipelined_scheduler_if.sv
// math_pipelined_scheduler_if: request/response bus between clients and the shared-ALU scheduler
interface math_pipelined_scheduler_if #(
    parameter int WIDTH      = 8,
    parameter int REQUESTERS = 4,
    parameter int ID_W       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
);
    logic [REQUESTERS-1:0]       req_valid;
    logic [REQUESTERS-1:0]       req_ready;
    logic [3*REQUESTERS-1:0]     req_op;
    logic [WIDTH*REQUESTERS-1:0] req_a;
    logic [WIDTH*REQUESTERS-1:0] req_b;
    logic [WIDTH*REQUESTERS-1:0] req_c;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [WIDTH-1:0]            rsp_data;
    modport master (
        output req_valid, req_op, req_a, req_b, req_c, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_c, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/math_pipelined_scheduler.sv
// math_pipelined_scheduler: round-robin sharing of one pipelined ALU among several clients
module math_pipelined_scheduler #(
    parameter int WIDTH       = 8,
    parameter int LATENCY     = 4,
    parameter int REQUESTERS  = 4,
    parameter int HOLD_CYCLES = LATENCY + 2
) (
    input  logic                      clk,
    input  logic                      rst,
    math_pipelined_scheduler_if.slave bus,
    output logic                      busy,
    output logic [WIDTH-1:0]          alu_i1,
    output logic [WIDTH-1:0]          alu_i2,
    output logic [WIDTH-1:0]          alu_i3,
    input  logic [WIDTH-1:0]          alu_sum,
    input  logic [WIDTH-1:0]          alu_sub,
    input  logic                      alu_and,
    input  logic                      alu_or,
    input  logic                      alu_xor,
    input  logic                      alu_eq,
    input  logic                      alu_neq
);
    localparam int ID_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

    state_t                  state, state_n;
    logic [ID_W-1:0]         ptr, grant;
    logic [2:0]              op, sel_op;
    logic [WIDTH-1:0]        sel_a, sel_b, sel_c, result;
    logic [CNT_W-1:0]        cnt;
    logic [2*REQUESTERS-1:0] rot;
    logic                    any, accept, bit_res;

    // rot[j] is the valid of client (ptr+1+j) mod REQUESTERS; the lowest set j wins
    always_comb begin
        rot = {bus.req_valid, bus.req_valid} >> (int'(ptr) + 1);
        any = |bus.req_valid;
        grant = '0;
        for (int j = REQUESTERS - 1; j >= 0; j--)
            if (rot[j]) grant = ID_W'((int'(ptr) + 1 + j) % REQUESTERS);
        sel_op = '0;
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int k = 0; k < REQUESTERS; k++)
            if (int'(grant) == k) begin
                sel_op = bus.req_op[3*k +: 3];
                sel_a = bus.req_a[WIDTH*k +: WIDTH];
                sel_b = bus.req_b[WIDTH*k +: WIDTH];
                sel_c = bus.req_c[WIDTH*k +: WIDTH];
            end
    end

    always_comb begin
        bit_res = op == 3'd2 ? alu_and : op == 3'd3 ? alu_or : op == 3'd4 ? alu_xor :
                  op == 3'd5 ? alu_eq : alu_neq;
        result = op == 3'd0 ? alu_sum : op == 3'd1 ? alu_sub : op == 3'd7 ? '0 : WIDTH'(bit_res);
    end

    always_comb begin
        accept = state == IDLE && any && !rst;
        state_n = state == IDLE ? (accept ? HOLD : IDLE) :
                  state == HOLD ? (cnt == '0 ? RESP : HOLD) :
                  (bus.rsp_ready ? IDLE : RESP);
        bus.req_ready = accept ? REQUESTERS'(1) << grant : '0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    assign busy = state != IDLE;

    // ptr doubles as the owner of the transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= ID_W'(REQUESTERS - 1);
            op <= '0;
            cnt <= '0;
            alu_i1 <= '0;
            alu_i2 <= '0;
            alu_i3 <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id <= '0;
            bus.rsp_data <= '0;
        end else begin
            if (accept) begin
                ptr <= grant;
                op <= sel_op;
                alu_i1 <= sel_a;
                alu_i2 <= sel_b;
                alu_i3 <= sel_c;
                cnt <= CNT_W'(HOLD_CYCLES - 1);
            end
            if (state == HOLD) cnt <= cnt - 1'b1;
            if (state == HOLD && cnt == '0) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_id <= ptr;
                bus.rsp_data <= result;
            end
            if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_math_pipelined_scheduler.sv
// tb_math_pipelined_scheduler: directed and random scoreboard checks of the shared-ALU scheduler
module tb_math_pipelined_scheduler;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int sel = 0;
    logic [R-1:0]   s_valid = '0;
    logic [3*R-1:0] s_op = '0;
    logic [8*R-1:0] s_a = '0, s_b = '0, s_c = '0;
    logic           s_rsp_ready = 1'b1;
    logic [7*R-1:0] a7, b7, c7;

    always_comb begin
        a7 = '0;
        b7 = '0;
        c7 = '0;
        for (int k = 0; k < R; k++) begin
            a7[7*k +: 7] = s_a[8*k +: 7];
            b7[7*k +: 7] = s_b[8*k +: 7];
            c7[7*k +: 7] = s_c[8*k +: 7];
        end
    end

    math_pipelined_scheduler_if #(.WIDTH(8), .REQUESTERS(R)) bus8 ();
    math_pipelined_scheduler_if #(.WIDTH(7), .REQUESTERS(R)) bus7a ();
    math_pipelined_scheduler_if #(.WIDTH(7), .REQUESTERS(R)) bus7b ();

    assign bus8.req_valid  = sel == 0 ? s_valid : '0;
    assign bus8.req_op     = s_op;
    assign bus8.req_a      = s_a;
    assign bus8.req_b      = s_b;
    assign bus8.req_c      = s_c;
    assign bus8.rsp_ready  = s_rsp_ready;
    assign bus7a.req_valid = sel == 1 ? s_valid : '0;
    assign bus7a.req_op    = s_op;
    assign bus7a.req_a     = a7;
    assign bus7a.req_b     = b7;
    assign bus7a.req_c     = c7;
    assign bus7a.rsp_ready = s_rsp_ready;
    assign bus7b.req_valid = sel == 2 ? s_valid : '0;
    assign bus7b.req_op    = s_op;
    assign bus7b.req_a     = a7;
    assign bus7b.req_b     = b7;
    assign bus7b.req_c     = c7;
    assign bus7b.rsp_ready = s_rsp_ready;

    logic       busy8, busy7a, busy7b;
    logic [7:0] i1_8, i2_8, i3_8;
    logic [6:0] i1_a, i2_a, i3_a, i1_b, i2_b, i3_b;

    // ALU stand-in: {sum, sub, and, or, xor, eq, neq} computed on masked operands
    function automatic logic [20:0] alu_pack(logic [7:0] i1, logic [7:0] i2, logic [7:0] i3, logic [7:0] m);
        logic [7:0] s, d;
        s = (i1 + i2) & m;
        d = (i1 - i2) & m;
        return {s, d, (i1 & m) == m, |(i1 & m), ^(i1 & m), (i1 & m) == (i3 & m), (i1 & m) != (i3 & m)};
    endfunction

    logic [20:0] p8 [4];
    logic [20:0] p7b [3];
    logic [20:0] pk8, pk7a, pk7b;

    always @(posedge clk) begin
        p8[0] <= alu_pack(i1_8, i2_8, i3_8, 8'hFF);
        for (int k = 1; k < 4; k++) p8[k] <= p8[k-1];
        p7b[0] <= alu_pack({1'b0, i1_b}, {1'b0, i2_b}, {1'b0, i3_b}, 8'h7F);
        for (int k = 1; k < 3; k++) p7b[k] <= p7b[k-1];
    end

    assign pk8  = p8[3];
    assign pk7a = alu_pack({1'b0, i1_a}, {1'b0, i2_a}, {1'b0, i3_a}, 8'h7F);
    assign pk7b = p7b[2];

    math_pipelined_scheduler #(.WIDTH(8), .LATENCY(4), .REQUESTERS(R)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8), .busy(busy8),
        .alu_i1(i1_8), .alu_i2(i2_8), .alu_i3(i3_8),
        .alu_sum(pk8[20:13]), .alu_sub(pk8[12:5]), .alu_and(pk8[4]), .alu_or(pk8[3]),
        .alu_xor(pk8[2]), .alu_eq(pk8[1]), .alu_neq(pk8[0])
    );
    math_pipelined_scheduler #(.WIDTH(7), .LATENCY(0), .REQUESTERS(R)) dut7a (
        .clk(clk), .rst(rst), .bus(bus7a), .busy(busy7a),
        .alu_i1(i1_a), .alu_i2(i2_a), .alu_i3(i3_a),
        .alu_sum(pk7a[19:13]), .alu_sub(pk7a[11:5]), .alu_and(pk7a[4]), .alu_or(pk7a[3]),
        .alu_xor(pk7a[2]), .alu_eq(pk7a[1]), .alu_neq(pk7a[0])
    );
    math_pipelined_scheduler #(.WIDTH(7), .LATENCY(3), .REQUESTERS(R)) dut7b (
        .clk(clk), .rst(rst), .bus(bus7b), .busy(busy7b),
        .alu_i1(i1_b), .alu_i2(i2_b), .alu_i3(i3_b),
        .alu_sum(pk7b[19:13]), .alu_sub(pk7b[11:5]), .alu_and(pk7b[4]), .alu_or(pk7b[3]),
        .alu_xor(pk7b[2]), .alu_eq(pk7b[1]), .alu_neq(pk7b[0])
    );

    logic [R-1:0] o_ready;
    logic         o_rv, o_busy;
    logic [1:0]   o_id;
    logic [7:0]   o_data, o_i1, o_i2, o_i3;

    always_comb begin
        o_ready = sel == 0 ? bus8.req_ready : sel == 1 ? bus7a.req_ready : bus7b.req_ready;
        o_rv    = sel == 0 ? bus8.rsp_valid : sel == 1 ? bus7a.rsp_valid : bus7b.rsp_valid;
        o_id    = sel == 0 ? bus8.rsp_id : sel == 1 ? bus7a.rsp_id : bus7b.rsp_id;
        o_data  = sel == 0 ? bus8.rsp_data : {1'b0, sel == 1 ? bus7a.rsp_data : bus7b.rsp_data};
        o_busy  = sel == 0 ? busy8 : sel == 1 ? busy7a : busy7b;
        o_i1    = sel == 0 ? i1_8 : {1'b0, sel == 1 ? i1_a : i1_b};
        o_i2    = sel == 0 ? i2_8 : {1'b0, sel == 1 ? i2_a : i2_b};
        o_i3    = sel == 0 ? i3_8 : {1'b0, sel == 1 ? i3_a : i3_b};
    end

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } exp_t;

    exp_t q[$];
    int grants[$];
    int vectors = 0, errs = 0, cyc = 0, ptr_m = R - 1;
    int acc_total = 0, acc_cyc = 0, rise_cyc = 0;
    logic prev_rv = 1'b0;
    logic [R-1:0] last_ready = '0;
    logic [7:0] last_data = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gold(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] m);
        logic [7:0] x, y, z;
        x = a & m;
        y = b & m;
        z = c & m;
        case (op)
            3'd0: return (x + y) & m;
            3'd1: return (x - y) & m;
            3'd2: return {7'd0, x == m};
            3'd3: return {7'd0, |x};
            3'd4: return {7'd0, ^x};
            3'd5: return {7'd0, x == z};
            3'd6: return {7'd0, x != z};
            default: return 8'h00;
        endcase
    endfunction

    task automatic set_req(int k, logic [2:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] c);
        s_valid[k] = 1'b1;
        s_op[3*k +: 3] = op;
        s_a[8*k +: 8] = a;
        s_b[8*k +: 8] = b;
        s_c[8*k +: 8] = c;
    endtask

    // One clock: sample grants and responses mid-cycle, then advance past the edge
    task automatic step();
        int g, k;
        logic [R-1:0] acc;
        logic [7:0] m;
        exp_t e;
        #1;
        m = sel == 0 ? 8'hFF : 8'h7F;
        last_ready = o_ready;
        acc = o_ready;
        if (o_ready != '0) begin
            g = -1;
            for (int i = 1; i <= R; i++) begin
                k = (ptr_m + i) % R;
                if (s_valid[k]) begin
                    g = k;
                    break;
                end
            end
            chk("grant", {28'd0, o_ready}, g >= 0 ? 32'(1) << g : 32'd0);
            if (g >= 0) begin
                ptr_m = g;
                e.id = 2'(g);
                e.a = s_a[8*g +: 8] & m;
                e.b = s_b[8*g +: 8] & m;
                e.c = s_c[8*g +: 8] & m;
                e.data = gold(s_op[3*g +: 3], e.a, e.b, e.c, m);
                q.push_back(e);
                grants.push_back(g);
                acc_cyc = cyc;
                acc_total++;
            end
        end
        if (o_rv && !prev_rv) rise_cyc = cyc;
        prev_rv = o_rv;
        if (o_rv && s_rsp_ready) begin
            chk("rsp_pending", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rsp_id", {30'd0, o_id}, {30'd0, e.id});
                chk("rsp_data", {24'd0, o_data}, {24'd0, e.data});
                chk("alu_ops", {8'd0, o_i1, o_i2, o_i3}, {8'd0, e.a, e.b, e.c});
                last_data = o_data;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        s_valid &= ~acc;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((s_valid != '0 || q.size() != 0 || o_busy) && n < budget) begin
            step();
            n++;
        end
        chk("drain_budget", {31'd0, n < budget}, 32'd1);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_ctl", {24'd0, o_rv, o_busy, o_ready, o_id}, 32'd0);
        chk("rst_data", {o_data, o_i1, o_i2, o_i3}, 32'd0);
        q.delete();
        s_valid = '0;
        ptr_m = R - 1;
        prev_rv = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic t4(logic [2:0] op, logic [7:0] a, logic [7:0] c, logic [7:0] exp);
        set_req(0, op, a, 8'h00, c);
        drain(50);
        chk($sformatf("t4_op%0d", op), {24'd0, last_data}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] ra, rc;
        logic [1:0] snap_id;
        logic [7:0] snap_data;
        int n;
        sel = 0;
        do_reset();

        // single SUM from client 2, 7-cycle accept-to-valid latency
        grants.delete();
        set_req(2, 3'd0, 8'hF0, 8'h20, 8'h00);
        step();
        chk("t1_ready", {28'd0, last_ready}, 32'h4);
        drain(50);
        chk("t1_latency", rise_cyc - acc_cyc, 32'd7);
        chk("t1_data", {24'd0, last_data}, 32'h10);
        chk("t1_accepts", grants.size(), 32'd1);

        // all four clients at once: grants rotate 0..3 after reset
        do_reset();
        grants.delete();
        for (int k = 0; k < R; k++) set_req(k, 3'd1, 8'h05, 8'h07, 8'h00);
        drain(100);
        chk("t2_count", grants.size(), 32'd4);
        for (int i = 0; i < R && i < grants.size(); i++) chk("t2_order", grants[i], i);
        chk("t2_data", {24'd0, last_data}, 32'hFE);

        // response stalled in RESP for 10 cycles
        s_rsp_ready = 1'b0;
        set_req(1, 3'd0, 8'h11, 8'h22, 8'h00);
        n = 0;
        while (!o_rv && n < 20) begin
            step();
            n++;
        end
        chk("t3_rv_wait", {31'd0, o_rv}, 32'd1);
        set_req(3, 3'd0, 8'h33, 8'h44, 8'h00);
        snap_id = o_id;
        snap_data = o_data;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_stall", {16'd0, o_rv, o_busy, o_ready, o_id, o_data}, {16'd0, 1'b1, 1'b1, 4'b0000, snap_id, snap_data});
        end
        s_rsp_ready = 1'b1;
        step();
        chk("t3_hs_ready", {28'd0, last_ready}, 32'd0);
        step();
        chk("t3_next", {28'd0, last_ready}, 32'h8);
        drain(50);
        chk("t3_data", {24'd0, last_data}, 32'h77);

        // single-bit and reserved opcodes
        t4(3'd5, 8'h5A, 8'h5A, 8'h01);
        t4(3'd6, 8'h5A, 8'h5A, 8'h00);
        t4(3'd4, 8'h07, 8'h00, 8'h01);
        t4(3'd2, 8'hFF, 8'h00, 8'h01);
        t4(3'd7, 8'h12, 8'h34, 8'h00);

        // reset while HOLD is in progress discards the transaction
        set_req(2, 3'd0, 8'h0A, 8'h0B, 8'h00);
        step();
        step();
        step();
        set_req(1, 3'd0, 8'h01, 8'h02, 8'h00);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_stale", {31'd0, o_rv}, 32'd0);
        end
        set_req(0, 3'd1, 8'h30, 8'h10, 8'h00);
        drain(50);
        chk("t5_data", {24'd0, last_data}, 32'h20);

        // random traffic on the two 7-bit instances
        for (int s = 1; s <= 2; s++) begin
            sel = s;
            do_reset();
            acc_total = 0;
            n = 0;
            while (acc_total < 2000 && n < 40000) begin
                for (int k = 0; k < R; k++)
                    if (!s_valid[k] && $urandom_range(2) == 0) begin
                        ra = 8'($urandom);
                        rc = $urandom_range(1) == 0 ? ra : 8'($urandom);
                        set_req(k, 3'($urandom_range(7)), ra, 8'($urandom), rc);
                    end
                s_rsp_ready = $urandom_range(3) != 0;
                step();
                n++;
            end
            chk("t6_budget", {31'd0, acc_total >= 2000}, 32'd1);
            s_rsp_ready = 1'b1;
            drain(500);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
